// File: rtl/if_prefetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage and its prefetch FIFO.
package if_prefetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous prefetch FIFO; flush clears pointers and count and takes priority over push/pop.
module if_prefetch_fifo
    import if_prefetch_stage_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = ptr_w(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // DEPTH is a power of two, so pointers wrap without compare logic
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: PC, redirect/flush, credit-limited prefetch into a FIFO.
// Optional IF_PERF_CNT_EN adds saturating Fetch_Cnt / Flush_Cnt outputs.
module if_prefetch_stage
    import if_prefetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  IMEM_AW    = 10,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Redirect,
    input  logic [PC_WIDTH-1:0] Redirect_Pc,
    output logic                Imem_En,
    output logic [IMEM_AW-1:0]  Imem_Addr,
    input  logic [INSTR_W-1:0]  Imem_Dout,
    output logic                Instr_Valid,
    input  logic                Instr_Ready,
    output logic [INSTR_W-1:0]  Instr,
    output logic [PC_WIDTH-1:0] Instr_Pc
`ifdef IF_PERF_CNT_EN
  , output logic [31:0]         Fetch_Cnt,
    output logic [31:0]         Flush_Cnt
`endif
);

    localparam int CW = ptr_w(FIFO_DEPTH) + 1;

    logic [PC_WIDTH-1:0]         pc;
    logic [PC_WIDTH-1:0]         req_pc;
    logic                        inflight;
    logic                        killed;
    logic [CW-1:0]               count;
    logic [INSTR_W+PC_WIDTH-1:0] head;
    logic                        push;
    logic                        pop;
    logic                        credit;
    logic                        unused_bits;

    // A same-cycle pop is deliberately not credited, keeping the issue path short
    assign credit    = (count + CW'(inflight)) < CW'(FIFO_DEPTH);
    assign Imem_En   = Reset_n && !Redirect && credit;
    assign Imem_Addr = pc[IMEM_AW+1:2];

    assign push        = inflight && !killed && !Redirect;
    assign Instr_Valid = (count != '0);
    assign pop         = Instr_Valid && Instr_Ready;
    assign {Instr, Instr_Pc} = Instr_Valid ? head : '0;

    assign unused_bits = ^{pc, Redirect_Pc[1:0]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            killed   <= 1'b0;
        end else if (Redirect) begin
            pc       <= {Redirect_Pc[PC_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            killed   <= 1'b1;
        end else begin
            killed   <= 1'b0;
            inflight <= Imem_En;
            if (Imem_En) begin
                pc     <= pc + PC_WIDTH'(PC_INC);
                req_pc <= pc;
            end
        end
    end

    if_prefetch_fifo #(
        .WIDTH (INSTR_W + PC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (push),
        .push_data ({Imem_Dout, req_pc}),
        .pop       (pop),
        .flush     (Redirect),
        .count     (count),
        .head      (head)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Fetch_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (push && Fetch_Cnt != '1)     Fetch_Cnt <= Fetch_Cnt + 32'd1;
            if (Redirect && Flush_Cnt != '1) Flush_Cnt <= Flush_Cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed sequences, a redirect table and a random program-order scoreboard.
module tb_if_prefetch_stage;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_Pc = '0;
    logic        Imem_En;
    logic [9:0]  Imem_Addr;
    logic [31:0] Imem_Dout = '0;
    logic        Instr_Valid;
    logic        Instr_Ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] Instr_Pc;

    logic        Redirect8 = 1'b0;
    logic [7:0]  Redirect_Pc8 = '0;
    logic        Imem_En8;
    logic [5:0]  Imem_Addr8;
    logic [31:0] Imem_Dout8 = '0;
    logic        Instr_Valid8;
    logic        Instr_Ready8 = 1'b1;
    logic [31:0] Instr8;
    logic [7:0]  Instr_Pc8;

`ifdef IF_PERF_CNT_EN
    logic [31:0] Fetch_Cnt, Flush_Cnt, Fetch_Cnt8, Flush_Cnt8;
`endif

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    if_prefetch_stage u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Redirect(Redirect), .Redirect_Pc(Redirect_Pc),
        .Imem_En(Imem_En), .Imem_Addr(Imem_Addr), .Imem_Dout(Imem_Dout),
        .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready), .Instr(Instr), .Instr_Pc(Instr_Pc)
`ifdef IF_PERF_CNT_EN
      , .Fetch_Cnt(Fetch_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
    );

    if_prefetch_stage #(.PC_WIDTH(8), .IMEM_AW(6)) u_w8 (
        .Clk(Clk), .Reset_n(Reset_n), .Redirect(Redirect8), .Redirect_Pc(Redirect_Pc8),
        .Imem_En(Imem_En8), .Imem_Addr(Imem_Addr8), .Imem_Dout(Imem_Dout8),
        .Instr_Valid(Instr_Valid8), .Instr_Ready(Instr_Ready8), .Instr(Instr8), .Instr_Pc(Instr_Pc8)
`ifdef IF_PERF_CNT_EN
      , .Fetch_Cnt(Fetch_Cnt8), .Flush_Cnt(Flush_Cnt8)
`endif
    );

    // Instruction memory: word n holds n, one-cycle synchronous read
    always @(posedge Clk) begin
        if (Imem_En)  Imem_Dout  <= {22'b0, Imem_Addr};
        if (Imem_En8) Imem_Dout8 <= {26'b0, Imem_Addr8};
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return (pc >> 2) & 32'h3FF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 8; i++) begin
            if (Instr_Valid) begin ok = 1; break; end
            next_cycle();
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for Instr_Valid", name);
        end
    endtask

    task automatic do_reset();
        #1 Reset_n = 1'b0;
        Redirect = 1'b0;
        next_cycle();
        Reset_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
    } redir_vec_t;

    redir_vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        logic [31:0] exp_pc;
        logic [7:0]  exp8 [3];
        bit prev_redir;
        int pops;

        tbl[0] = '{32'h0000_0203, 32'h0000_0200};
        tbl[1] = '{32'h0000_0100, 32'h0000_0100};
        tbl[2] = '{32'h0000_07FF, 32'h0000_07FC};
        tbl[3] = '{32'h0000_0041, 32'h0000_0040};
        tbl[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};

        // 1. reset state, then continuous streaming
        Instr_Ready = 1'b1;
        #3;
        check("rst_valid", Instr_Valid, 0);
        check("rst_en", Imem_En, 0);
        check("rst_instr", Instr, 0);
        check("rst_pc", Instr_Pc, 0);
        next_cycle();
        Reset_n = 1'b1;
        #1;
        check("first_issue_en", Imem_En, 1);
        check("first_issue_addr", Imem_Addr, 0);
        wait_valid("first_valid");
        check("stream_pc0", Instr_Pc, 0);
        check("stream_instr0", Instr, 0);
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            #1;
            check("stream_valid", Instr_Valid, 1);
            check("stream_pc", Instr_Pc, 32'(4 * i));
            check("stream_instr", Instr, 32'(i));
        end

        // 2. decode stall for 10 cycles from reset
        Instr_Ready = 1'b0;
        do_reset();
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            en_cnt += int'(Imem_En);
            next_cycle();
        end
        #1;
        check("stall_issue_count", en_cnt, 4);
        check("stall_en_off", Imem_En, 0);
        check("stall_valid", Instr_Valid, 1);
        Instr_Ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("release_valid", Instr_Valid, 1);
            check("release_pc", Instr_Pc, 32'(4 * k));
            next_cycle();
        end

        // 3. redirect with 3 entries buffered and one read in flight
        Instr_Ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) next_cycle();
        Redirect = 1'b1;
        Redirect_Pc = 32'h100;
        #1;
        check("redir_en_low", Imem_En, 0);
        check("redir_full_valid", Instr_Valid, 1);
        next_cycle();
        Redirect = 1'b0;
        Instr_Ready = 1'b1;
        #1;
        check("redir_flush_valid", Instr_Valid, 0);
        wait_valid("redir_resume");
        check("redir_pc", Instr_Pc, 32'h100);
        check("redir_instr", Instr, 32'h40);
        next_cycle();
        #1;
        wait_valid("redir_next");
        check("redir_pc_next", Instr_Pc, 32'h104);

        // 4. redirect table (alignment of target) and back-to-back redirects
        for (int v = 0; v < 5; v++) begin
`ifdef IF_PERF_CNT_EN
            logic [31:0] fl0;
            fl0 = Flush_Cnt;
`endif
            next_cycle();
            Redirect = 1'b1;
            Redirect_Pc = tbl[v].target;
            #1;
            check("tbl_en_low", Imem_En, 0);
            next_cycle();
            Redirect = 1'b0;
            #1;
            check("tbl_valid_low", Instr_Valid, 0);
`ifdef IF_PERF_CNT_EN
            check("tbl_flush_cnt", Flush_Cnt, fl0 + 32'd1);
`endif
            wait_valid("tbl_resume");
            check("tbl_pc", Instr_Pc, tbl[v].exp_pc);
            check("tbl_instr", Instr, word_at(tbl[v].exp_pc));
        end
        next_cycle();
        Redirect = 1'b1;
        Redirect_Pc = 32'h40;
        next_cycle();
        Redirect_Pc = 32'h80;
        next_cycle();
        Redirect = 1'b0;
        #1;
        check("b2b_valid_low", Instr_Valid, 0);
        wait_valid("b2b_resume");
        check("b2b_pc", Instr_Pc, 32'h80);

        // 5. 8-bit PC wraps past 0xFC
        exp8 = '{8'hFC, 8'h00, 8'h04};
        next_cycle();
        Redirect8 = 1'b1;
        Redirect_Pc8 = 8'hFC;
        next_cycle();
        Redirect8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int w = 0;
            #1;
            while (!Instr_Valid8 && w < 8) begin next_cycle(); #1; w++; end
            check("wrap_pc", Instr_Pc8, exp8[k]);
            check("wrap_instr", Instr8, 32'(exp8[k] >> 2));
            next_cycle();
        end

        // random ready/redirect against a program-order scoreboard
        do_reset();
        exp_pc = '0;
        prev_redir = 0;
        pops = 0;
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            Instr_Ready = ($urandom_range(0, 9) < 7);
            Redirect = ($urandom_range(0, 19) == 0);
            Redirect_Pc = $urandom;
            #1;
            if (Redirect) check("rnd_en_redir", Imem_En, 0);
            if (prev_redir) check("rnd_valid_after_redir", Instr_Valid, 0);
            if (!Instr_Valid) check("rnd_empty_pc", Instr_Pc, 0);
            if (Instr_Valid && Instr_Ready) begin
                check("rnd_pc", Instr_Pc, exp_pc);
                check("rnd_instr", Instr, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (Redirect) exp_pc = Redirect_Pc & 32'hFFFF_FFFC;
            prev_redir = Redirect;
        end
        check("rnd_progress", (pops > 100), 1);

        // 6. asynchronous reset pulse mid-stream
        next_cycle();
        Redirect = 1'b0;
        Instr_Ready = 1'b1;
        for (int i = 0; i < 6; i++) next_cycle();
        #2;
        check("pre_pulse_valid", Instr_Valid, 1);
        Reset_n = 1'b0;
        #1;
        check("pulse_valid", Instr_Valid, 0);
        check("pulse_en", Imem_En, 0);
`ifdef IF_PERF_CNT_EN
        check("pulse_fetch_cnt", Fetch_Cnt, 0);
        check("pulse_flush_cnt", Flush_Cnt, 0);
`endif
        #1;
        Reset_n = 1'b1;
        #1;
        check("pulse_refetch_addr", Imem_Addr, 0);
        wait_valid("pulse_resume");
        check("pulse_pc", Instr_Pc, 0);
        check("pulse_instr", Instr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
